// File: rtl/seq_mult.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per cycle, start/busy/valid handshake.
// Optional SEQ_MULT_ZERO_SKIP_EN: a zero operand bypasses RUN and completes in one cycle.
module seq_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;

  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_shift;
  logic                 w_last;

  // The adder carry lands directly in the accumulator MSB on the shift,
  // so it never needs to be held across cycles.
  assign w_addend    = r_acc[0] ? r_mcand : '0;
  assign w_sum       = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_acc_shift = {w_sum, r_acc[WIDTH-1:1]};
  assign w_last      = (r_cnt == CW'(1));

`ifdef SEQ_MULT_ZERO_SKIP_EN
  logic w_zero;
  assign w_zero = (a == '0) || (b == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef SEQ_MULT_ZERO_SKIP_EN
          w_state_next = w_zero ? S_DONE : S_RUN;
`else
          w_state_next = S_RUN;
`endif
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // busy/valid are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      valid   <= 1'b0;
      product <= '0;
      ovf     <= 1'b0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      busy  <= (w_state_next != S_IDLE);
      valid <= (w_state_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= a;
            r_acc   <= {{WIDTH{1'b0}}, b};
            r_cnt   <= CW'(WIDTH);
`ifdef SEQ_MULT_ZERO_SKIP_EN
            if (w_zero) begin
              product <= '0;
              ovf     <= 1'b0;
              r_cnt   <= '0;
            end
`endif
          end
        end
        S_RUN: begin
          r_acc <= w_acc_shift;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            product <= w_acc_shift;
            ovf     <= |w_acc_shift[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Randomized self-checking bench for seq_mult against a plain a*b reference with latency model.
module tb_seq_mult;

  localparam int unsigned WIDTH = 8;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               valid;
  logic [2*WIDTH-1:0] product;
  logic               ovf;

  int unsigned n_cmp;
  int unsigned n_err;

  seq_mult #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .valid   (valid),
    .product (product),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: product is the exact integer product; latency depends only on the build and zero operands.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_op, input bit pulse_mid);
    int unsigned cyc;
    int unsigned busy_cnt;
    int unsigned exp_lat;
    int unsigned exp_p;
    exp_p   = int'(ta) * int'(tb_op);
    exp_lat = WIDTH + 1;
`ifdef SEQ_MULT_ZERO_SKIP_EN
    if (ta == 0 || tb_op == 0) exp_lat = 1;
`endif
    start = 1'b1;
    a     = ta;
    b     = tb_op;
    tick();
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    cyc      = 1;
    busy_cnt = 0;
    while (!valid && cyc < 40) begin
      if (busy) busy_cnt++;
      if (pulse_mid && cyc == 3) begin
        start = 1'b1;
        a     = 3;
        b     = 3;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    if (busy) busy_cnt++;
    check("latency", cyc, exp_lat);
    check("busy_len", busy_cnt, exp_lat);
    check("product", 32'(product), exp_p);
    check("ovf", 32'(ovf), 32'(exp_p >= (1 << WIDTH)));
    tick();
    check("valid_pulse", 32'(valid), 0);
    check("busy_fall", 32'(busy), 0);
    check("product_hold", 32'(product), exp_p);
  endtask

  initial begin
    int unsigned cyc;
    int unsigned low_cnt;
    int unsigned extra_valid;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_product", 32'(product), 0);
    check("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;
    tick();

    run_op(8'd13, 8'd11, 1'b0);
    run_op(8'd255, 8'd255, 1'b0);
    run_op(8'd16, 8'd16, 1'b0);
    run_op(8'd0, 8'd200, 1'b0);
    run_op(8'd200, 8'd0, 1'b0);
    run_op(8'd1, 8'd255, 1'b0);

    // Start pulsed mid-RUN must be ignored and produce no second result.
    run_op(8'd7, 8'd9, 1'b1);
    extra_valid = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid) extra_valid++;
      tick();
    end
    check("no_second_valid", extra_valid, 0);

    // Asynchronous reset in the middle of RUN.
    start = 1'b1;
    a     = 8'd100;
    b     = 8'd100;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_valid", 32'(valid), 0);
    check("arst_product", 32'(product), 0);
    check("arst_ovf", 32'(ovf), 0);
    tick();
    rst_n = 1'b1;
    extra_valid = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid || busy) extra_valid++;
      tick();
    end
    check("arst_no_resume", extra_valid, 0);
    run_op(8'd5, 8'd6, 1'b0);

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    start = 1'b1;
    a     = 8'd2;
    b     = 8'd3;
    cyc   = 0;
    while (!valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check("held_first", 32'(valid), 1);
    for (int k = 0; k < 3; k++) begin
      cyc     = 0;
      low_cnt = 0;
      do begin
        tick();
        cyc++;
        if (!busy) low_cnt++;
      end while (!valid && cyc < 40);
      check("held_interval", cyc, WIDTH + 2);
      check("held_gap", low_cnt, 1);
      check("held_product", 32'(product), 6);
    end
    start = 1'b0;
    tick();
    tick();

    // Randomized operands, with zeros injected often enough to exercise that path.
    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) ra = '0;
      if ($urandom_range(0, 7) == 0) rb = '0;
      run_op(ra, rb, 1'b0);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
